// File: rtl/light_pwm_driver_pkg.sv
// Shared types and constants for the lamp PWM driver.
// Holds the FSM encoding, level widths and the one-step ramp helper.
package light_pwm_driver_pkg;

  localparam int unsigned LEVEL_W   = 4;
  localparam int unsigned LEVEL_MAX = 15;
  localparam int unsigned PWM_STEPS = 15;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_IDLE = 2'd1,
    ST_RAMP = 2'd2
  } state_t;

  function automatic logic [LEVEL_W-1:0] step_toward(
    input logic [LEVEL_W-1:0] cur,
    input logic [LEVEL_W-1:0] tgt
  );
    logic [LEVEL_W-1:0] r;
    r = cur;
    if (cur < tgt)
      r = cur + 1'b1;
    else if (cur > tgt)
      r = cur - 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/light_pwm_timebase.sv
// PWM timebase: prescaler tick plus 0..14 period counter.
// boundary marks the tick on which the period counter wraps.
module light_pwm_timebase
  import light_pwm_driver_pkg::*;
#(
  parameter int unsigned PRESCALE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               tick,
  output logic [LEVEL_W-1:0] period_cnt,
  output logic               boundary
);

  localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);
  localparam logic [LEVEL_W-1:0] PER_LAST =
    LEVEL_W'(PWM_STEPS - 1);

  logic [7:0] pre_cnt;

  assign tick     = (pre_cnt == PRE_LAST);
  assign boundary = tick && (period_cnt == PER_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt    <= '0;
      period_cnt <= '0;
    end else begin
      pre_cnt <= tick ? 8'd0 : pre_cnt + 8'd1;
      if (tick)
        period_cnt <= (period_cnt == PER_LAST) ?
                      '0 : period_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/light_pwm_driver.sv
// Lamp PWM driver: level handshake, ramp FSM and registered PWM.
// Level changes land only on period boundaries to avoid runt pulses.
module light_pwm_driver
  import light_pwm_driver_pkg::*;
#(
  parameter int unsigned PRESCALE     = 4,
  parameter int unsigned RAMP_PERIODS = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [LEVEL_W-1:0] level_in,
  input  logic               level_valid,
  output logic               level_ready,
  output logic               pwm_out,
  output logic [LEVEL_W-1:0] cur_level,
  output logic               busy
);

  localparam logic [7:0] RAMP_LAST = 8'(RAMP_PERIODS - 1);

  state_t             state, state_nxt;
  logic [LEVEL_W-1:0] target, target_nxt;
  logic [LEVEL_W-1:0] cur_nxt;
  logic [7:0]         ramp_cnt, ramp_cnt_nxt;
  logic               accept;
  logic               tick;
  logic               boundary;
  logic [LEVEL_W-1:0] period_cnt;

  light_pwm_timebase #(
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .period_cnt (period_cnt),
    .boundary   (boundary)
  );

  // rst_n gates ready so it reads 0 for the whole reset window
  assign level_ready = rst_n &&
    (state == ST_OFF || state == ST_IDLE);
  assign busy   = (state == ST_RAMP);
  assign accept = level_valid && level_ready;

  always_comb begin
    target_nxt   = accept ? level_in : target;
    state_nxt    = state;
    cur_nxt      = cur_level;
    ramp_cnt_nxt = '0;
    if (!enable) begin
      state_nxt = ST_OFF;
      cur_nxt   = '0;
    end else begin
      case (state)
        ST_OFF: begin
          cur_nxt   = '0;
          state_nxt = (target_nxt != '0) ? ST_RAMP : ST_IDLE;
        end
        ST_IDLE: begin
          if (accept && level_in != cur_level)
            state_nxt = ST_RAMP;
        end
        ST_RAMP: begin
          ramp_cnt_nxt = ramp_cnt;
          if (boundary) begin
            if (ramp_cnt == RAMP_LAST) begin
              ramp_cnt_nxt = '0;
              cur_nxt = step_toward(cur_level, target);
              if (cur_nxt == target)
                state_nxt = ST_IDLE;
            end else begin
              ramp_cnt_nxt = ramp_cnt + 8'd1;
            end
          end
        end
        default: begin
          state_nxt = ST_OFF;
          cur_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_OFF;
      target    <= '0;
      cur_level <= '0;
      ramp_cnt  <= '0;
      pwm_out   <= 1'b0;
    end else begin
      state     <= state_nxt;
      target    <= target_nxt;
      cur_level <= cur_nxt;
      ramp_cnt  <= ramp_cnt_nxt;
      pwm_out   <= enable && (period_cnt < cur_level);
    end
  end

endmodule

// File: tb/tb_light_pwm_driver.sv
// Directed bench for light_pwm_driver, PRESCALE=2, RAMP_PERIODS=1.
// One PWM period is 30 clocks; outputs sampled on the falling edge.
module tb_light_pwm_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [3:0] level_in;
  logic       level_valid;
  logic       level_ready;
  logic       pwm_out;
  logic [3:0] cur_level;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  light_pwm_driver #(
    .PRESCALE     (2),
    .RAMP_PERIODS (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .level_in    (level_in),
    .level_valid (level_valid),
    .level_ready (level_ready),
    .pwm_out     (pwm_out),
    .cur_level   (cur_level),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_lvl(input logic [3:0] lv,
                          input int budget,
                          input string tag);
    int n = 0;
    while (cur_level !== lv && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(cur_level), 32'(lv));
  endtask

  task automatic send(input logic [3:0] lv);
    level_in    = lv;
    level_valid = 1'b1;
    @(negedge clk);
    level_valid = 1'b0;
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (pwm_out === 1'b1) hi++;
    end
  endtask

  initial begin
    int t_prev;
    int hi;
    int min_run;
    int run;
    int seen;
    int steps;
    int badstep;
    int n;
    logic prev_pwm;
    logic [3:0] prev_cur;

    rst_n       = 1'b0;
    enable      = 1'b0;
    level_in    = 4'd0;
    level_valid = 1'b0;
    t_prev      = 0;
    #12;
    chk("rst_pwm", 32'(pwm_out), 0);
    chk("rst_cur", 32'(cur_level), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(level_ready), 0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("off_ready", 32'(level_ready), 1);
    @(negedge clk);

    // ramp 0 -> 5, one step per 30 clocks
    enable = 1'b1;
    send(4'd5);
    chk("ramp_busy", 32'(busy), 1);
    chk("ramp_ready", 32'(level_ready), 0);
    for (int lv = 1; lv <= 5; lv++) begin
      wait_lvl(4'(lv), 40, "ramp_up_lvl");
      if (lv >= 2)
        chk("step_interval", 32'(cyc - t_prev), 30);
      t_prev = cyc;
      if (lv == 2) begin
        level_in    = 4'd9;
        level_valid = 1'b1;
        chk("ignore_ready", 32'(level_ready), 0);
        @(negedge clk);
        level_valid = 1'b0;
      end
    end
    chk("at5_busy", 32'(busy), 0);
    chk("at5_ready", 32'(level_ready), 1);
    repeat (60) @(negedge clk);
    chk("target_kept5", 32'(cur_level), 5);

    count_high(30, hi);
    chk("duty5", 32'(hi), 10);
    count_high(30, hi);
    chk("duty5_b", 32'(hi), 10);

    // up to 8, then down to 3 watching pulse widths
    send(4'd8);
    wait_lvl(4'd8, 120, "up_to8");
    send(4'd3);
    min_run  = 1000;
    run      = 0;
    seen     = 0;
    steps    = 0;
    badstep  = 0;
    n        = 0;
    prev_pwm = pwm_out;
    prev_cur = cur_level;
    while (cur_level !== 4'd3 && n < 200) begin
      @(negedge clk);
      n++;
      if (pwm_out !== prev_pwm) begin
        if (seen != 0 && run < min_run) min_run = run;
        seen = 1;
        run  = 1;
      end else begin
        run++;
      end
      if (cur_level !== prev_cur) begin
        steps++;
        if (cur_level !== prev_cur - 4'd1) badstep++;
      end
      prev_pwm = pwm_out;
      prev_cur = cur_level;
    end
    chk("down_lvl3", 32'(cur_level), 3);
    chk("down_steps", 32'(steps), 5);
    chk("down_unit", 32'(badstep), 0);
    chk("min_pulse_ok", 32'(min_run >= 2), 1);

    // level 0 and level 15 extremes
    send(4'd0);
    wait_lvl(4'd0, 120, "down_to0");
    count_high(60, hi);
    chk("lvl0_high", 32'(hi), 0);
    send(4'd15);
    wait_lvl(4'd15, 500, "up_to15");
    count_high(60, hi);
    chk("lvl15_low", 32'(60 - hi), 0);

    // enable drop; accept while disabled stays OFF
    enable = 1'b0;
    @(negedge clk);
    chk("dis_cur", 32'(cur_level), 0);
    chk("dis_pwm", 32'(pwm_out), 0);
    send(4'd10);
    chk("dis_accept_busy", 32'(busy), 0);
    chk("dis_accept_cur", 32'(cur_level), 0);
    enable = 1'b1;
    @(negedge clk);
    chk("reen_busy", 32'(busy), 1);
    wait_lvl(4'd4, 150, "mid_lvl4");
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("drop_pwm", 32'(pwm_out), 0);
    chk("drop_cur", 32'(cur_level), 0);
    chk("drop_busy", 32'(busy), 0);
    @(negedge clk);
    enable = 1'b1;
    wait_lvl(4'd10, 350, "restore_to10");
    chk("restore_busy", 32'(busy), 0);

    // async reset mid-ramp
    send(4'd2);
    wait_lvl(4'd9, 60, "rst_mid_lvl9");
    chk("rst_mid_busy", 32'(busy), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_pwm", 32'(pwm_out), 0);
    chk("arst_cur", 32'(cur_level), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ready", 32'(level_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(level_ready), 1);
    chk("post_rst_busy", 32'(busy), 0);
    @(negedge clk);
    chk("post_rst_idle", 32'(busy), 0);
    count_high(60, hi);
    chk("post_rst_cur", 32'(cur_level), 0);
    chk("post_rst_pwm", 32'(hi), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/light_pwm_driver.md
LIGHT_PWM_DRIVER -- requirements
Module: light_pwm_driver

Interface
REQ-001 Parameter PRESCALE, default 4: clocks per PWM tick, legal range 1..255.
REQ-002 Parameter RAMP_PERIODS, default 2: complete PWM periods per one-step ramp move, legal range 1..255.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  lamp enable; 0 forces the lamp off.
REQ-006 level_in  input  4  requested brightness level, 0..15, from the light controller.
REQ-007 level_valid  input  1  level_in is valid this cycle.
REQ-008 level_ready  output  1  driver accepts a new level this cycle.
REQ-009 pwm_out  output  1  registered lamp drive.
REQ-010 cur_level  output  4  brightness currently applied.
REQ-011 busy  output  1  high while ramping.

Function
REQ-012 Prescaler SHALL count 0..PRESCALE-1 and SHALL emit a one-clock tick on its terminal count; it SHALL run whenever rst_n=1.
REQ-013 Period counter SHALL advance 0..14 on each tick and wrap 14->0; the wrap tick SHALL be the period boundary, so one period = 15*PRESCALE clocks.
REQ-014 pwm_out SHALL be registered as (enable && period_cnt < cur_level): level 0 gives constant 0, level 15 gives constant 1, level N gives N ticks high then 15-N ticks low.
REQ-015 Handshake: a transfer SHALL occur when level_valid && level_ready on a rising edge; the target register SHALL capture level_in on that edge.
REQ-016 level_ready SHALL be 1 only in IDLE and OFF; level_valid while level_ready=0 SHALL be ignored, with no queuing.
REQ-017 FSM states SHALL be OFF, IDLE and RAMP.
REQ-018 OFF: cur_level=0 and pwm_out=0. enable 1 with target != 0 SHALL go to RAMP; enable 1 with target = 0 SHALL go to IDLE.
REQ-019 IDLE: an accepted level different from cur_level SHALL go to RAMP on the next cycle; an accepted level equal to cur_level SHALL stay in IDLE.
REQ-020 RAMP: at every RAMP_PERIODS-th period boundary, cur_level SHALL move exactly one step toward target, up or down. When cur_level equals target after a step, the state SHALL go to IDLE.
REQ-021 cur_level SHALL change only on a period boundary, so no truncated or glitched PWM pulses occur; the ramp-period counter SHALL clear on RAMP entry.
REQ-022 busy SHALL equal (state == RAMP).
REQ-023 enable falling in any state SHALL go to OFF on the next edge, set cur_level=0 and drive pwm_out=0 from that edge. target SHALL be retained.
REQ-024 Simultaneous accepted level and enable=0: target SHALL be updated and the state SHALL be OFF.
REQ-025 Arithmetic SHALL be unsigned 4-bit with no wrap: ramp up SHALL saturate at target ≤ 15, and ramp down SHALL stop at target ≥ 0.

Reset
REQ-026 While rst_n=0, state SHALL be OFF and cur_level, target, all counters, pwm_out, busy and level_ready SHALL all be 0.
REQ-027 After rst_n deasserts, the first rising edge SHALL evaluate normally; assertion mid-ramp SHALL abort the ramp immediately and asynchronously.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, LEVEL_W=4, LEVEL_MAX=15 and PWM_STEPS=15.
REQ-029 The PWM timebase (prescaler plus period counter, outputs tick/period_cnt/boundary) SHALL be the sub-module light_pwm_timebase; the FSM and ramp SHALL be in the top level.

Verification (PRESCALE=2, RAMP_PERIODS=1)
REQ-030 Reset then enable=1, level_in=5 accepted: cur_level steps 0->1->...->5, one step every 30 clocks; busy=0 and level_ready=1 after reaching 5.
REQ-031 Steady at level 5: pwm_out is high exactly 10 of every 30 clocks. Level 0 gives pwm_out never high; level 15 gives pwm_out never low.
REQ-032 level_valid with 9 during RAMP toward 5 -> ignored; target remains 5.
REQ-033 At level 8, accept 3 -> ramp down 8->3 in 5 boundaries; no pwm pulse shorter than 2 clocks at any transition.
REQ-034 enable dropped mid-ramp at level 4 (target 10) -> pwm_out=0 next edge, cur_level=0; enable restored -> ramp 0->10.
REQ-035 rst_n pulsed low mid-ramp -> all outputs 0 asynchronously; after release, state OFF and target 0.
